piso_serializer: RTL and testbench

Parallel-in serial-out transmitter: the outbound end of the team's shift-register datapath, the serial counterpart of the existing parallel-in parallel-out register. It accepts WIDTH-bit words through a valid/ready handshake and emits each word one bit per clock with a frame-start marker. A one-word holding buffer allows back-to-back words to stream with no idle cycles between frames.

---
 rtl/piso_serializer_pkg.sv | 17 +
 rtl/piso_serializer_if.sv | 37 +++
 rtl/piso_shift_reg.sv | 35 +++
 rtl/piso_serializer.sv | 119 +++++++++++
 tb/tb_piso_serializer.sv | 139 +++++++++++++
 5 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter:
// FSM state type, default word width and counter sizing helper.
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bits needed to count bit positions 0..width-1.
  function automatic int cntWidth(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-load handshake plus serial output bundle of the PISO transmitter.
// The master side supplies words; the slave side is the serializer.
interface piso_serializer_if
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] datain;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output datain,
    output load_valid,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  frame_start,
    input  busy
  );

  modport slave (
    input  datain,
    input  load_valid,
    output load_ready,
    output sout,
    output sout_valid,
    output frame_start,
    output busy
  );

endinterface

// File: rtl/piso_shift_reg.sv
// WIDTH-bit shift register with parallel load and selectable output end.
// Load takes priority over shift; the serial bit is taken from the output end.
module piso_shift_reg
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
    end else if (i_shift) begin
      if (MSB_FIRST) begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      end else begin
        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      end
    end
  end

  assign o_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: FSM, bit counter and a one-word hold
// buffer so that back-to-back words stream with no idle cycle between frames.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  piso_serializer_if.slave  bus
);

  localparam int             CW   = cntWidth(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cntNext;
  logic [WIDTH-1:0] r_hold;
  logic             r_holdFull;
  logic             w_holdFullNext;
  logic             w_holdLoad;
  logic             w_shLoad;
  logic             w_shShift;
  logic             w_selHold;
  logic             w_accept;
  logic             w_loadReady;
  logic             w_serialBit;
  logic [WIDTH-1:0] w_loadData;

  assign w_loadReady = !r_holdFull && !rst;
  assign w_accept    = bus.load_valid && w_loadReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_holdFull <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= w_cntNext;
      r_holdFull <= w_holdFullNext;
      if (w_holdLoad) begin
        r_hold <= bus.datain;
      end
    end
  end

  // On the last bit a buffered word wins over a fresh one; the fresh word
  // cannot arrive then anyway because load_ready is low while the buffer is full.
  always_comb begin
    w_nextState    = r_state;
    w_cntNext      = r_cnt;
    w_holdFullNext = r_holdFull;
    w_holdLoad     = 1'b0;
    w_shLoad       = 1'b0;
    w_shShift      = 1'b0;
    w_selHold      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_shLoad    = 1'b1;
          w_cntNext   = '0;
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt != LAST) begin
          w_shShift = 1'b1;
          w_cntNext = r_cnt + CW'(1);
          if (w_accept) begin
            w_holdLoad     = 1'b1;
            w_holdFullNext = 1'b1;
          end
        end else if (r_holdFull) begin
          w_shLoad       = 1'b1;
          w_selHold      = 1'b1;
          w_holdFullNext = 1'b0;
          w_cntNext      = '0;
        end else if (w_accept) begin
          w_shLoad  = 1'b1;
          w_cntNext = '0;
        end else begin
          w_cntNext   = '0;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  assign w_loadData = w_selHold ? r_hold : bus.datain;

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_shLoad),
    .i_shift (w_shShift),
    .i_data  (w_loadData),
    .o_bit   (w_serialBit)
  );

  // The shifter keeps leftover bits after a frame ends, so sout is gated.
  assign bus.sout        = w_serialBit && (r_state == SHIFT);
  assign bus.sout_valid  = (r_state == SHIFT);
  assign bus.frame_start = (r_state == SHIFT) && (r_cnt == '0);
  assign bus.busy        = (r_state == SHIFT);
  assign bus.load_ready  = w_loadReady;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances share one stimulus
// stream and are compared against a bit-queue model of the transmitted stream.
module tb_piso_serializer;
  import piso_serializer_pkg::*;

  localparam int W      = 4;
  localparam int CYCLES = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loadValid;
  logic [W-1:0] dataIn;

  int testsRun    = 0;
  int testsFailed = 0;

  // Bits still to appear on sout, oldest first, with frame-start markers.
  logic qMsb[$];
  logic qLsb[$];
  logic qFirst[$];

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) busMsb ();
  piso_serializer_if #(.WIDTH(W)) busLsb ();

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busMsb.slave)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
    .clk (clk),
    .rst (rst),
    .bus (busLsb.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected, input int cyc);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, observed, expected);
    end
  endtask

  // Directed scenarios first, then randomized traffic with occasional resets.
  task automatic applyStimulus(input int cyc);
    logic [W-1:0] word;
    word      = W'($urandom);
    rst       = 1'b0;
    loadValid = 1'b0;
    dataIn    = word;
    if (cyc < 3) begin
      rst = 1'b1;
    end else if (cyc == 3) begin
      loadValid = 1'b1; dataIn = 4'b1001;
    end else if (cyc == 10) begin
      loadValid = 1'b1; dataIn = 4'b0001;
    end else if (cyc == 11) begin
      loadValid = 1'b1; dataIn = 4'b0010;
    end else if (cyc == 21) begin
      loadValid = 1'b1; dataIn = 4'b0010;
    end else if (cyc == 25) begin
      loadValid = 1'b1; dataIn = 4'b0011;
    end else if (cyc == 32) begin
      loadValid = 1'b1; dataIn = 4'b1001;
    end else if (cyc == 33) begin
      loadValid = 1'b1; dataIn = 4'b0001;
    end else if (cyc == 34) begin
      rst = 1'b1;
    end else if (cyc == 36) begin
      loadValid = 1'b1; dataIn = 4'b0010;
    end else if (cyc >= 42) begin
      rst       = ($urandom_range(0, 49) == 0);
      loadValid = ($urandom_range(0, 9) < 6);
    end
    busMsb.datain     = dataIn;
    busMsb.load_valid = loadValid;
    busLsb.datain     = dataIn;
    busLsb.load_valid = loadValid;
  endtask

  initial begin
    logic expValid, expMsb, expLsb, expFirst, expReady, accept;
    busMsb.load_valid = 1'b0;
    busLsb.load_valid = 1'b0;
    busMsb.datain     = '0;
    busLsb.datain     = '0;
    loadValid         = 1'b0;
    dataIn            = '0;
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      applyStimulus(cyc);
      #1;
      expValid = (qMsb.size() > 0);
      expMsb   = expValid ? qMsb[0]   : 1'b0;
      expLsb   = expValid ? qLsb[0]   : 1'b0;
      expFirst = expValid ? qFirst[0] : 1'b0;
      // A word beyond the one in flight means the hold buffer is occupied.
      expReady = !rst && (qMsb.size() <= W);
      accept   = loadValid && expReady;

      checkOutput("msb.sout",        32'(busMsb.sout),        32'(expMsb),   cyc);
      checkOutput("msb.sout_valid",  32'(busMsb.sout_valid),  32'(expValid), cyc);
      checkOutput("msb.frame_start", 32'(busMsb.frame_start), 32'(expFirst), cyc);
      checkOutput("msb.busy",        32'(busMsb.busy),        32'(expValid), cyc);
      checkOutput("msb.load_ready",  32'(busMsb.load_ready),  32'(expReady), cyc);
      checkOutput("lsb.sout",        32'(busLsb.sout),        32'(expLsb),   cyc);
      checkOutput("lsb.sout_valid",  32'(busLsb.sout_valid),  32'(expValid), cyc);
      checkOutput("lsb.frame_start", 32'(busLsb.frame_start), 32'(expFirst), cyc);
      checkOutput("lsb.load_ready",  32'(busLsb.load_ready),  32'(expReady), cyc);

      @(posedge clk);
      if (rst) begin
        qMsb.delete();
        qLsb.delete();
        qFirst.delete();
      end else begin
        if (qMsb.size() > 0) begin
          void'(qMsb.pop_front());
          void'(qLsb.pop_front());
          void'(qFirst.pop_front());
        end
        if (accept) begin
          for (int i = 0; i < W; i++) begin
            qMsb.push_back(dataIn[W-1-i]);
            qLsb.push_back(dataIn[i]);
            qFirst.push_back(i == 0);
          end
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
